// File: rtl/tl_buf_pkg.sv
// Shared TileLink buffer definitions: channel opcodes and the count-width helper.
package tl_buf_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } aOpcode_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2
  } dOpcode_e;

  localparam int MAX_DEPTH = 16;

  // A depth-0 channel still needs a one-bit count port that is tied to zero.
  function automatic int cntWidth(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tl_ad_buffer_param_if.sv
// One TileLink-UL/UH link (A request and D response channels) with master/slave views.
interface tl_ad_buffer_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 1,
    parameter int SINK_W = 1,
    parameter int SIZE_W = 2
);
  logic                  aValid;
  logic                  aReady;
  logic [2:0]            aOpcode;
  logic [2:0]            aParam;
  logic [SIZE_W-1:0]     aSize;
  logic [SRC_W-1:0]      aSource;
  logic [ADDR_W-1:0]     aAddress;
  logic [DATA_W/8-1:0]   aMask;
  logic [DATA_W-1:0]     aData;
  logic                  aCorrupt;

  logic                  dValid;
  logic                  dReady;
  logic [2:0]            dOpcode;
  logic [1:0]            dParam;
  logic [SIZE_W-1:0]     dSize;
  logic [SRC_W-1:0]      dSource;
  logic [SINK_W-1:0]     dSink;
  logic                  dDenied;
  logic [DATA_W-1:0]     dData;
  logic                  dCorrupt;

  modport master (
    output aValid, aOpcode, aParam, aSize, aSource, aAddress, aMask, aData, aCorrupt,
    input  aReady,
    input  dValid, dOpcode, dParam, dSize, dSource, dSink, dDenied, dData, dCorrupt,
    output dReady
  );

  modport slave (
    input  aValid, aOpcode, aParam, aSize, aSource, aAddress, aMask, aData, aCorrupt,
    output aReady,
    output dValid, dOpcode, dParam, dSize, dSource, dSink, dDenied, dData, dCorrupt,
    input  dReady
  );

endinterface

// File: rtl/tl_buf_queue.sv
// Circular-buffer queue on an opaque packed payload with optional flow-through and
// pipelined-full behaviour; depth 0 degenerates to a plain wire.
module tl_buf_queue
  import tl_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter bit FLOW  = 1'b0,
    parameter bit PIPE  = 1'b0,
    parameter int W     = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [W-1:0]               inData,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [W-1:0]               outData,
    output logic [cntWidth(DEPTH)-1:0] count
);

  localparam int CNT_W = cntWidth(DEPTH);

  if (DEPTH == 0) begin : gWire
    logic unusedClkRst;
    assign unusedClkRst = clock ^ reset_n;
    assign outValid     = inValid;
    assign outData      = inData;
    assign inReady      = outReady;
    assign count        = '0;
  end else begin : gQueue
    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] enqPtr, deqPtr;
    logic             maybeFull;
    logic [CNT_W-1:0] cnt;
    logic             ptrEq, empty, full, doEnq, doDeq;

    assign ptrEq    = (enqPtr == deqPtr);
    assign empty    = ptrEq && !maybeFull;
    assign full     = ptrEq && maybeFull;
    assign outValid = !empty || (FLOW && inValid);
    assign outData  = (FLOW && empty) ? inData : mem[deqPtr];
    assign inReady  = !full || (PIPE && outReady);
    assign count    = cnt;

    // A beat that flows straight through an empty queue is never written to storage.
    assign doEnq = inValid && inReady && !(FLOW && empty && outReady);
    assign doDeq = outValid && outReady && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        enqPtr    <= '0;
        deqPtr    <= '0;
        maybeFull <= 1'b0;
        cnt       <= '0;
      end else begin
        if (doEnq) enqPtr <= (enqPtr == LAST) ? '0 : enqPtr + 1'b1;
        if (doDeq) deqPtr <= (deqPtr == LAST) ? '0 : deqPtr + 1'b1;
        if (doEnq != doDeq) begin
          maybeFull <= doEnq;
          cnt       <= doEnq ? cnt + 1'b1 : cnt - 1'b1;
        end
      end
    end

    // NOTE: payload storage is deliberately left unreset; the pointers alone define validity.
    always_ff @(posedge clock) begin
      if (doEnq) mem[enqPtr] <= inData;
    end
  end

endmodule

// File: rtl/tl_ad_buffer_param.sv
// TileLink A/D buffer: one independently configured queue per channel, plus
// occupancy counts and a quiescence flag for clock gating and drain logic.
module tl_ad_buffer_param
  import tl_buf_pkg::*;
#(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int A_FLOW  = 0,
    parameter int A_PIPE  = 0,
    parameter int D_FLOW  = 0,
    parameter int D_PIPE  = 0,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SRC_W   = 1,
    parameter int SINK_W  = 1,
    parameter int SIZE_W  = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    tl_ad_buffer_param_if.slave          up,
    tl_ad_buffer_param_if.master         down,
    output logic [cntWidth(A_DEPTH)-1:0] a_count,
    output logic [cntWidth(D_DEPTH)-1:0] d_count,
    output logic                         idle
);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [SIZE_W-1:0]   size;
    logic [SRC_W-1:0]    source;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } aBeat_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [SINK_W-1:0] sink;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } dBeat_t;

  aBeat_t aIn, aOut;
  dBeat_t dIn, dOut;

  assign aIn = '{opcode: up.aOpcode, param: up.aParam, size: up.aSize, source: up.aSource,
                 address: up.aAddress, mask: up.aMask, data: up.aData, corrupt: up.aCorrupt};

  tl_buf_queue #(
    .DEPTH (A_DEPTH),
    .FLOW  (A_FLOW != 0),
    .PIPE  (A_PIPE != 0),
    .W     ($bits(aBeat_t))
  ) aQueue (
    .clock    (clock),
    .reset_n  (reset_n),
    .inValid  (up.aValid),
    .inReady  (up.aReady),
    .inData   (aIn),
    .outValid (down.aValid),
    .outReady (down.aReady),
    .outData  (aOut),
    .count    (a_count)
  );

  assign down.aOpcode  = aOut.opcode;
  assign down.aParam   = aOut.param;
  assign down.aSize    = aOut.size;
  assign down.aSource  = aOut.source;
  assign down.aAddress = aOut.address;
  assign down.aMask    = aOut.mask;
  assign down.aData    = aOut.data;
  assign down.aCorrupt = aOut.corrupt;

  assign dIn = '{opcode: down.dOpcode, param: down.dParam, size: down.dSize, source: down.dSource,
                 sink: down.dSink, denied: down.dDenied, data: down.dData, corrupt: down.dCorrupt};

  tl_buf_queue #(
    .DEPTH (D_DEPTH),
    .FLOW  (D_FLOW != 0),
    .PIPE  (D_PIPE != 0),
    .W     ($bits(dBeat_t))
  ) dQueue (
    .clock    (clock),
    .reset_n  (reset_n),
    .inValid  (down.dValid),
    .inReady  (down.dReady),
    .inData   (dIn),
    .outValid (up.dValid),
    .outReady (up.dReady),
    .outData  (dOut),
    .count    (d_count)
  );

  assign up.dOpcode  = dOut.opcode;
  assign up.dParam   = dOut.param;
  assign up.dSize    = dOut.size;
  assign up.dSource  = dOut.source;
  assign up.dSink    = dOut.sink;
  assign up.dDenied  = dOut.denied;
  assign up.dData    = dOut.data;
  assign up.dCorrupt = dOut.corrupt;

  // Counts are registered, so an empty queue plus no pending input means nothing can move.
  assign idle = (a_count == '0) && (d_count == '0) && !up.aValid && !down.dValid;

endmodule
